fifo_watermark: RTL and testbench

Parametrised synchronous FIFO with programmable high/low watermarks, hysteretic flow-control pause, occupancy count and sticky classified error reporting. It is the next-generation buffer between the data source and sink stages, replacing the fixed-depth FIFO with a single error flag. Width and depth are parameters, and the limits are run-time inputs.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_mem.sv | 38 +++
 rtl/fifo_watermark.sv | 154 +++++++++++++++
 tb/tb_fifo_watermark.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, pause-state encoding and width helper for the watermark FIFO.
package fifo_pkg;

    localparam int unsigned ERR_OVF  = 0;
    localparam int unsigned ERR_UNF  = 1;
    localparam int unsigned ERR_BITS = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } pause_state_t;

    // Occupancy counter must represent 0..2^addr_bits inclusive.
    function automatic int unsigned count_bits(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the watermark FIFO.
// Synchronous write port; registered read port that holds its last word.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS = 10,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Array is not reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_watermark.sv
// Synchronous FIFO with live high/low watermarks, hysteretic pause and sticky error code.
// Optional macro FIFO_ERR_CLR_EN adds an error_clear input that clears the sticky code.
module fifo_watermark
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_BITS = 10,
    parameter int unsigned ADDR_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_BITS-1:0]   fifo_data_in,
    input  logic                   fifo_write,
    input  logic                   fifo_read,
    input  logic [ADDR_BITS:0]     high_limit,
    input  logic [ADDR_BITS:0]     low_limit,
`ifdef FIFO_ERR_CLR_EN
    input  logic                   error_clear,
`endif
    output logic [DATA_BITS-1:0]   fifo_data_out,
    output logic                   fifo_full_out,
    output logic                   fifo_empty_out,
    output logic                   almost_full_out,
    output logic                   almost_empty_out,
    output logic                   pause_out,
    output logic [ADDR_BITS:0]     fifo_count_out,
    output logic                   error_fifo_out,
    output logic [ERR_BITS-1:0]    error_code_out
);

    localparam int unsigned CW    = count_bits(ADDR_BITS);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic [ERR_BITS-1:0]  err_code;
    pause_state_t         state;
    pause_state_t         state_next;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic ovf;
    logic unf;
    logic err_clr;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    // A read frees a slot in the same cycle, so write-while-full is legal with a read.
    assign wr_acc = fifo_write && (!full || fifo_read);
    assign rd_acc = fifo_read && !empty;
    assign ovf    = fifo_write && full && !fifo_read;
    assign unf    = fifo_read && empty;

`ifdef FIFO_ERR_CLR_EN
    assign err_clr = error_clear;
`else
    assign err_clr = 1'b0;
`endif

    fifo_mem #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (fifo_data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (fifo_data_out)
    );

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pause hysteresis: enter on high watermark, leave on low watermark.
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if ((high_limit != '0) && (count_next >= high_limit)) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (count_next <= low_limit) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            count <= count_next;
        end
    end

    // Sticky errors; a fresh error in the clearing cycle still lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_code <= '0;
        end else begin
            if (err_clr) begin
                err_code <= '0;
            end
            if (ovf) begin
                err_code[ERR_OVF] <= 1'b1;
            end
            if (unf) begin
                err_code[ERR_UNF] <= 1'b1;
            end
        end
    end

    assign fifo_full_out    = full;
    assign fifo_empty_out   = empty;
    assign fifo_count_out   = count;
    assign almost_full_out  = (high_limit != '0) && (count >= high_limit);
    assign almost_empty_out = (count <= low_limit);
    assign pause_out        = (state == ST_PAUSE);
    assign error_code_out   = err_code;
    assign error_fifo_out   = |err_code;

endmodule

// File: tb/tb_fifo_watermark.sv
// Directed, table-driven bench for fifo_watermark (DATA_BITS=10, ADDR_BITS=3, limits 6/2).
module tb_fifo_watermark;

    localparam int unsigned DB = 10;
    localparam int unsigned AB = 3;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DB-1:0] din;
        logic [DB-1:0] dout;
        logic [AB:0]   cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          pause;
        logic [1:0]    err;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] fifo_data_in = '0;
    logic          fifo_write = 1'b0;
    logic          fifo_read = 1'b0;
    logic [AB:0]   high_limit = 4'd6;
    logic [AB:0]   low_limit = 4'd2;
    logic [DB-1:0] fifo_data_out;
    logic          fifo_full_out;
    logic          fifo_empty_out;
    logic          almost_full_out;
    logic          almost_empty_out;
    logic          pause_out;
    logic [AB:0]   fifo_count_out;
    logic          error_fifo_out;
    logic [1:0]    error_code_out;

    int checks = 0;
    int failures = 0;

    fifo_watermark #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk              (clk),
        .reset            (reset),
        .fifo_data_in     (fifo_data_in),
        .fifo_write       (fifo_write),
        .fifo_read        (fifo_read),
        .high_limit       (high_limit),
        .low_limit        (low_limit),
`ifdef FIFO_ERR_CLR_EN
        .error_clear      (1'b0),
`endif
        .fifo_data_out    (fifo_data_out),
        .fifo_full_out    (fifo_full_out),
        .fifo_empty_out   (fifo_empty_out),
        .almost_full_out  (almost_full_out),
        .almost_empty_out (almost_empty_out),
        .pause_out        (pause_out),
        .fifo_count_out   (fifo_count_out),
        .error_fifo_out   (error_fifo_out),
        .error_code_out   (error_code_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic wr, input logic rd, input logic [DB-1:0] din,
                                input logic [DB-1:0] dout, input logic [AB:0] cnt,
                                input logic full, input logic empty, input logic af,
                                input logic ae, input logic pause, input logic [1:0] err);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.cnt = cnt;
        v.full = full; v.empty = empty; v.af = af; v.ae = ae; v.pause = pause; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        chk({tag, " dout"},  16'(fifo_data_out),    16'(e.dout));
        chk({tag, " count"}, 16'(fifo_count_out),   16'(e.cnt));
        chk({tag, " full"},  16'(fifo_full_out),    16'(e.full));
        chk({tag, " empty"}, 16'(fifo_empty_out),   16'(e.empty));
        chk({tag, " afull"}, 16'(almost_full_out),  16'(e.af));
        chk({tag, " aempty"},16'(almost_empty_out), 16'(e.ae));
        chk({tag, " pause"}, 16'(pause_out),        16'(e.pause));
        chk({tag, " ecode"}, 16'(error_code_out),   16'(e.err));
        chk({tag, " eflag"}, 16'(error_fifo_out),   16'(|e.err));
    endtask

    // Drive one cycle of requests, sample 1 time unit after the edge.
    task automatic step(input logic wr, input logic rd, input logic [DB-1:0] din);
        fifo_write = wr;
        fifo_read = rd;
        fifo_data_in = din;
        @(posedge clk);
        #1;
        fifo_write = 1'b0;
        fifo_read = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[17];
    vec_t rst_v;

    initial begin
        //            wr    rd    din     dout    cnt   full  empty af    ae    pause err
        tbl[0]  = mk(1'b1, 1'b0, 10'h001, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        tbl[1]  = mk(1'b1, 1'b0, 10'h002, 10'h000, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        tbl[2]  = mk(1'b1, 1'b0, 10'h003, 10'h000, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[3]  = mk(1'b1, 1'b0, 10'h004, 10'h000, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[4]  = mk(1'b1, 1'b0, 10'h005, 10'h000, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        tbl[5]  = mk(1'b1, 1'b0, 10'h006, 10'h000, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        tbl[6]  = mk(1'b1, 1'b0, 10'h007, 10'h000, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        tbl[7]  = mk(1'b1, 1'b0, 10'h008, 10'h000, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        tbl[8]  = mk(1'b1, 1'b0, 10'h3FF, 10'h000, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        tbl[9]  = mk(1'b0, 1'b1, 10'h000, 10'h001, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        tbl[10] = mk(1'b0, 1'b1, 10'h000, 10'h002, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01);
        tbl[11] = mk(1'b0, 1'b1, 10'h000, 10'h003, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        tbl[12] = mk(1'b0, 1'b1, 10'h000, 10'h004, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        tbl[13] = mk(1'b0, 1'b1, 10'h000, 10'h005, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        tbl[14] = mk(1'b0, 1'b1, 10'h000, 10'h006, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        tbl[15] = mk(1'b0, 1'b1, 10'h000, 10'h007, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01);
        tbl[16] = mk(1'b0, 1'b1, 10'h000, 10'h008, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
        rst_v   = mk(1'b0, 1'b0, 10'h000, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);

        // Reset state while clock runs
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", rst_v);
        reset = 1'b0;

        // Fill, overflow, drain
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din);
            check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Read while empty, then a write: underflow sticks
        pulse_reset();
        check_all("reset2", rst_v);
        step(1'b0, 1'b1, 10'h000);
        check_all("unf_read", mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10));
        step(1'b1, 1'b0, 10'h155);
        check_all("unf_write", mk(1'b1, 1'b0, 10'h155, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10));

        // Empty with simultaneous read+write: write taken, read rejected
        pulse_reset();
        step(1'b1, 1'b1, 10'h111);
        check_all("empty_rw", mk(1'b1, 1'b1, 10'h111, 10'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
        step(1'b0, 1'b1, 10'h000);
        check_all("empty_rw_rd", mk(1'b0, 1'b1, 10'h000, 10'h111, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10));

        // Full with simultaneous read+write
        pulse_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 10'(16 + i));
        step(1'b1, 1'b1, 10'h2AA);
        check_all("full_rw", mk(1'b1, 1'b1, 10'h2AA, 10'h010, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00));
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 1'b1, 10'h000);
            chk($sformatf("full_rw_rd%0d dout", i), 16'(fifo_data_out), 16'(16 + i));
        end
        step(1'b0, 1'b1, 10'h000);
        check_all("full_rw_last", mk(1'b0, 1'b1, 10'h000, 10'h2AA, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00));

        // Asynchronous reset mid-stream with count=5
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'(32 + i));
        step(1'b0, 1'b1, 10'h000);
        step(1'b1, 1'b0, 10'h025);
        check_all("pre_areset", mk(1'b0, 1'b0, 10'h000, 10'h020, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
        #2;
        reset = 1'b1;
        #1;
        check_all("areset", rst_v);
        reset = 1'b0;
        step(1'b0, 1'b1, 10'h000);
        check_all("post_areset_rd", mk(1'b0, 1'b1, 10'h000, 10'h000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
